pkt_decoder: RTL
================

PKT_DECODER -- requirements
Module: pkt_decoder

Interface
REQ-001 Parameter N_DST, default 8: number of destination channels, 1..256.
REQ-002 Parameter FIFO_DEPTH, default 256: payload buffer depth in bytes, power of two, at least 256.
REQ-003 Parameter TIMEOUT_CYC, default 2500000: idle-byte timeout in clk cycles (50 ms at 50 MHz).
REQ-004 Parameter PREFIX, default 8'hA5: start-of-packet byte.
REQ-005 Parameter OWN_ADDR, default 8'h01: this node's address byte.
REQ-006 clk  in  1  clock; all logic on rising edge.
REQ-007 n_rst  in  1  reset, asynchronous, active-low.
REQ-008 rx_data  in  8  received byte.
REQ-009 rx_valid  in  1  rx_data valid.
REQ-010 rx_ready  out  1  decoder accepts rx_data; a byte transfers when rx_valid and rx_ready are both high.
REQ-011 q  out  8  payload byte to the destination.
REQ-012 valid_bus  out  N_DST  one-hot; bit dest high while q is valid for that channel.
REQ-013 ready_bus  in  N_DST  per-channel ready; a byte transfers when valid_bus[dest] and ready_bus[dest] are both high.
REQ-014 err_crc, err_dest, err_len, err_timeout  out  1 each  one-cycle error pulses.
REQ-015 busy  out  1  high whenever the state is not IDLE.

Function
REQ-016 Frame: PREFIX, OWN_ADDR, DEST, LEN, LEN payload bytes, CRC; CRC is the modulo-256 sum of the payload bytes.
REQ-017 States: IDLE, ADDR, DEST, LEN, DATA, CRC, FWD; each state except FWD advances only on an accepted byte.
REQ-018 IDLE: PREFIX -> ADDR; any other byte is ignored.
REQ-019 ADDR: OWN_ADDR -> DEST; any other byte -> IDLE, with no error pulse.
REQ-020 DEST: latch the byte as dest -> LEN.
REQ-021 LEN: LEN = 0 -> IDLE with err_len pulse; otherwise latch len -> DATA.
REQ-022 DATA: write each byte to the FIFO and accumulate the 8-bit sum; after the len-th byte -> CRC.
REQ-023 CRC, byte matches sum and dest < N_DST: -> FWD.
REQ-024 CRC, byte mismatches sum: -> IDLE, err_crc pulse, FIFO cleared.
REQ-025 CRC, byte matches but dest >= N_DST: -> IDLE, err_dest pulse, FIFO cleared.
REQ-026 If CRC and dest both fail, err_crc alone pulses.
REQ-027 FWD: q = FIFO head (show-ahead); valid_bus = one-hot(dest) while the FIFO is non-empty; all other bits 0.
REQ-028 FWD: each cycle with ready_bus[dest] high pops one byte; the ready_bus bits of other channels are ignored.
REQ-029 FWD: when the last byte pops -> IDLE on the same edge; the first payload byte is valid the cycle after the CRC byte is accepted.
REQ-030 rx_ready = 0 in FWD and 0 in DATA when the FIFO is full; 1 otherwise.
REQ-031 In FWD, q and valid_bus are held stable while ready_bus[dest] is low, with no time limit.
REQ-032 The sum accumulator and byte counter clear on every entry to IDLE.
REQ-033 Timeout counter clears on each accepted byte, and is held at 0 in IDLE and FWD.
REQ-034 On reaching TIMEOUT_CYC-1 the block synchronously -> IDLE, clears the FIFO and pulses err_timeout for one cycle.
REQ-035 When a byte arrives on the timeout cycle, the timeout wins and the byte is dropped.
REQ-036 Simultaneous FIFO write and FIFO clear: the clear wins.

Reset
REQ-037 Asynchronous n_rst low: state IDLE; dest, len, counter, sum, timeout counter = 0; FIFO empty.
REQ-038 Outputs during reset: valid_bus = 0, all error pulses = 0, busy = 0, rx_ready = 1, q = 0.
REQ-039 Reset in mid-packet or mid-FWD discards all buffered payload; no partial output resumes after release.

Structure
REQ-040 PREFIX/OWN_ADDR defaults, state encodings and the timeout default live in the shared defines header.
REQ-041 Payload buffer is one sub-module, pkt_fifo: synchronous show-ahead FIFO with sclr, depth FIFO_DEPTH, and empty/full flags.
REQ-042 The timeout counter is sized to $clog2(TIMEOUT_CYC).

Verification
REQ-043 Send A5 01 02 03 10 20 30 60 -> valid_bus=8'h04, q=10,20,30 on consecutive cycles with ready_bus all ones; busy falls after 30.
REQ-044 Same frame with CRC byte 61 -> err_crc pulse, valid_bus stays 0, next good frame forwarded correctly.
REQ-045 Frame with DEST=09, N_DST=8, correct CRC -> err_dest pulse, no output; frame with LEN=00 -> err_len pulse, return to IDLE.
REQ-046 Stall after the second DATA byte for TIMEOUT_CYC cycles -> err_timeout pulse, FIFO empty, following good frame forwarded.
REQ-047 FWD with ready_bus[2] toggling 1010... and other bits high -> each byte held until accepted, no loss or duplication, rx_ready=0 throughout FWD.
REQ-048 Assert n_rst during DATA and again during FWD -> all outputs at reset values, no stale bytes after release.

Source files
------------

// File: rtl/pkt_decoder_pkg.sv
// Shared defaults, state encoding and sizing helpers for the packet decoder slice.
package pkt_decoder_pkg;

  localparam logic [7:0] PREFIX_DEFAULT   = 8'hA5;
  localparam logic [7:0] OWN_ADDR_DEFAULT = 8'h01;
  localparam int         TIMEOUT_DEFAULT  = 2500000;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ADDR = 3'd1,
    ST_DEST = 3'd2,
    ST_LEN  = 3'd3,
    ST_DATA = 3'd4,
    ST_CRC  = 3'd5,
    ST_FWD  = 3'd6
  } state_t;

  // A one-cycle timeout still needs a one-bit counter.
  function automatic int timeout_width(input int cyc);
    return (cyc > 1) ? $clog2(cyc) : 1;
  endfunction

endpackage

// File: rtl/pkt_fifo.sv
// Synchronous show-ahead payload FIFO with synchronous clear; clear beats a same-cycle write.
module pkt_fifo
  import pkt_decoder_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     n_rst,
  input  logic                     sclr,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int         AW      = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_wr;
  logic             do_rd;

  assign count = wr_ptr - rd_ptr;
  assign empty = (count == '0);
  assign full  = (count == (AW+1)'(DEPTH));
  assign do_wr = wr_en && !full && !sclr;
  assign do_rd = rd_en && !empty && !sclr;

  // The extra pointer bit separates full from empty.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (sclr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_rd) rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  assign rd_data = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/pkt_decoder.sv
// Frame decoder: PREFIX, OWN_ADDR, DEST, LEN, payload, CRC; buffers the payload and
// forwards it to one of N_DST ready/valid channels once the frame checks out.
module pkt_decoder
  import pkt_decoder_pkg::*;
#(
  parameter int         N_DST       = 8,
  parameter int         FIFO_DEPTH  = 256,
  parameter int         TIMEOUT_CYC = TIMEOUT_DEFAULT,
  parameter logic [7:0] PREFIX      = PREFIX_DEFAULT,
  parameter logic [7:0] OWN_ADDR    = OWN_ADDR_DEFAULT
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  output logic             rx_ready,
  output logic [7:0]       q,
  output logic [N_DST-1:0] valid_bus,
  input  logic [N_DST-1:0] ready_bus,
  output logic             err_crc,
  output logic             err_dest,
  output logic             err_len,
  output logic             err_timeout,
  output logic             busy
);

  localparam int          AW       = $clog2(FIFO_DEPTH);
  localparam int          TW       = timeout_width(TIMEOUT_CYC);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [TW-1:0] TO_ONE  = TW'(1);
  localparam logic [AW:0] ONE_LEFT = (AW+1)'(1);

  state_t        state, state_next;
  logic [7:0]    dest, len, cnt, sum;
  logic [TW-1:0] to_cnt;

  logic          fifo_wr, fifo_rd, fifo_clr;
  logic          fifo_empty, fifo_full;
  logic [7:0]    fifo_q;
  logic [AW:0]   fifo_count;

  logic          accept, byte_ok, timeout_hit, dest_ok;
  logic          fwd_valid, ready_sel;
  logic          crc_fail, dest_fail, len_fail;

  pkt_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk     (clk),
    .n_rst   (n_rst),
    .sclr    (fifo_clr),
    .wr_en   (fifo_wr),
    .wr_data (rx_data),
    .rd_en   (fifo_rd),
    .rd_data (fifo_q),
    .empty   (fifo_empty),
    .full    (fifo_full),
    .count   (fifo_count)
  );

  assign rx_ready    = (state != ST_FWD) && !((state == ST_DATA) && fifo_full);
  assign accept      = rx_valid && rx_ready;
  assign timeout_hit = (state inside {ST_ADDR, ST_DEST, ST_LEN, ST_DATA, ST_CRC}) &&
                       (to_cnt == TO_LAST);
  // A byte landing on the timeout cycle is dropped.
  assign byte_ok     = accept && !timeout_hit;
  assign dest_ok     = ({1'b0, dest} < 9'(N_DST));
  assign fwd_valid   = (state == ST_FWD) && !fifo_empty;
  assign q           = fwd_valid ? fifo_q : 8'h00;
  assign busy        = (state != ST_IDLE);

  // Loop compare keeps dest indexing in range for any N_DST.
  always_comb begin
    valid_bus = '0;
    ready_sel = 1'b0;
    for (int i = 0; i < N_DST; i++) begin
      valid_bus[i] = fwd_valid && (dest == 8'(i));
      ready_sel    = ready_sel | (ready_bus[i] && (dest == 8'(i)));
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    fifo_wr    = 1'b0;
    fifo_rd    = 1'b0;
    fifo_clr   = 1'b0;
    crc_fail   = 1'b0;
    dest_fail  = 1'b0;
    len_fail   = 1'b0;
    if (timeout_hit) begin
      state_next = ST_IDLE;
      fifo_clr   = 1'b1;
    end else begin
      unique case (state)
        ST_IDLE: if (byte_ok && (rx_data == PREFIX)) state_next = ST_ADDR;
        ST_ADDR: if (byte_ok) state_next = (rx_data == OWN_ADDR) ? ST_DEST : ST_IDLE;
        ST_DEST: if (byte_ok) state_next = ST_LEN;
        ST_LEN: begin
          if (byte_ok) begin
            if (rx_data == 8'h00) begin
              state_next = ST_IDLE;
              len_fail   = 1'b1;
            end else begin
              state_next = ST_DATA;
            end
          end
        end
        ST_DATA: begin
          if (byte_ok) begin
            fifo_wr = 1'b1;
            if (cnt == len - 8'd1) state_next = ST_CRC;
          end
        end
        ST_CRC: begin
          if (byte_ok) begin
            if (rx_data != sum) begin
              state_next = ST_IDLE;
              crc_fail   = 1'b1;
              fifo_clr   = 1'b1;
            end else if (!dest_ok) begin
              state_next = ST_IDLE;
              dest_fail  = 1'b1;
              fifo_clr   = 1'b1;
            end else begin
              state_next = ST_FWD;
            end
          end
        end
        ST_FWD: begin
          if (fifo_empty) begin
            state_next = ST_IDLE;
          end else if (ready_sel) begin
            fifo_rd = 1'b1;
            if (fifo_count == ONE_LEFT) state_next = ST_IDLE;
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  // Frame bookkeeping; error flags are registered so each is a clean one-cycle pulse.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      dest        <= 8'h00;
      len         <= 8'h00;
      cnt         <= 8'h00;
      sum         <= 8'h00;
      to_cnt      <= '0;
      err_crc     <= 1'b0;
      err_dest    <= 1'b0;
      err_len     <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      err_crc     <= crc_fail;
      err_dest    <= dest_fail;
      err_len     <= len_fail;
      err_timeout <= timeout_hit;
      if ((state == ST_DEST) && byte_ok) dest <= rx_data;
      if ((state == ST_LEN) && byte_ok)  len  <= rx_data;
      if (state_next == ST_IDLE) begin
        cnt <= 8'h00;
        sum <= 8'h00;
      end else if (fifo_wr) begin
        cnt <= cnt + 8'd1;
        sum <= sum + rx_data;
      end
      if ((state_next == ST_IDLE) || (state_next == ST_FWD) || byte_ok) to_cnt <= '0;
      else                                                               to_cnt <= to_cnt + TO_ONE;
    end
  end

endmodule
